// File: rtl/funct_generator_reader.sv
// Read-side pacer for the function-generator sample FIFO: issues one FIFO read per
// sample period, converts signed fixed-point samples to offset-binary DAC codes.
module funct_generator_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int INT_BITS   = 4,
    parameter int DAC_WIDTH  = 12,
    parameter int DIV_WIDTH  = 16,
    parameter int RESET_DIV  = 99
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_i,
    input  logic                  div_load_i,
    input  logic [DIV_WIDTH-1:0]  div_i,
    input  logic                  empty_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  rd_en_o,
    output logic [DAC_WIDTH-1:0]  dac_data_o,
    output logic                  dac_valid_o,
    output logic                  underrun_o,
    output logic [15:0]           underrun_cnt_o,
    output logic                  busy_o
);

    localparam int FRAC = DATA_WIDTH - INT_BITS;
    localparam logic [DAC_WIDTH-1:0] MIDSCALE = {1'b1, {(DAC_WIDTH-1){1'b0}}};
    localparam logic [DIV_WIDTH-1:0] RST_PERIOD = DIV_WIDTH'(RESET_DIV);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e                 state_q;
    logic [DIV_WIDTH-1:0]   period_q;
    logic [DIV_WIDTH-1:0]   cnt_q;
    logic                   drain_q;

    // Slot pipeline: stage 1 marks a tick from the previous cycle, stage 2 is the output.
    logic                   slot_rd_q;
    logic                   slot_und_q;
    logic [DAC_WIDTH-1:0]   dac_q;
    logic [DAC_WIDTH-1:0]   dac_d;
    logic                   valid_q;
    logic                   und_q;
    logic [15:0]            ucnt_q;
    logic [15:0]            ucnt_d;

    logic                   tick;
    logic                   start;
    logic [INT_BITS-1:0]    int_part;
    logic                   in_range;

    assign tick    = (state_q == RUN) && en_i && (cnt_q == period_q);
    assign start   = (state_q == IDLE) && en_i;
    assign rd_en_o = tick && !empty_i;

    assign dac_data_o     = dac_q;
    assign dac_valid_o    = valid_q;
    assign underrun_o     = und_q;
    assign underrun_cnt_o = ucnt_q;
    assign busy_o         = (state_q != IDLE);

    // Integer field all-equal means |s| < 1.0 and the sample fits the DAC range.
    assign int_part = data_i[DATA_WIDTH-1:FRAC];
    assign in_range = (&int_part) | ~(|int_part);

    always_comb begin
        dac_d                = data_i[FRAC -: DAC_WIDTH];
        dac_d[DAC_WIDTH-1]   = ~dac_d[DAC_WIDTH-1];
        if (!in_range) begin
            dac_d = data_i[DATA_WIDTH-1] ? '0 : '1;
        end
    end

    always_comb begin
        ucnt_d = ucnt_q;
        if (start) begin
            ucnt_d = '0;
        end else if (slot_und_q && (ucnt_q != 16'hFFFF)) begin
            ucnt_d = ucnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            period_q <= RST_PERIOD;
            cnt_q    <= '0;
            drain_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (div_load_i) period_q <= div_i;
                    if (en_i) begin
                        state_q <= RUN;
                        // Start aligned so the first RUN cycle is a tick, even on a same-cycle load.
                        cnt_q   <= div_load_i ? div_i : period_q;
                    end
                end
                RUN: begin
                    if (!en_i) begin
                        state_q <= DRAIN;
                        drain_q <= 1'b0;
                    end else begin
                        cnt_q <= tick ? '0 : cnt_q + 1'b1;
                    end
                end
                DRAIN: begin
                    drain_q <= 1'b1;
                    if (drain_q) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_rd_q  <= 1'b0;
            slot_und_q <= 1'b0;
            dac_q      <= MIDSCALE;
            valid_q    <= 1'b0;
            und_q      <= 1'b0;
            ucnt_q     <= '0;
        end else begin
            slot_rd_q  <= rd_en_o;
            slot_und_q <= tick && empty_i;
            valid_q    <= slot_rd_q;
            und_q      <= slot_und_q;
            ucnt_q     <= ucnt_d;
            if (slot_rd_q) dac_q <= dac_d;
        end
    end

endmodule

// File: tb/tb_funct_generator_reader.sv
// Bench for funct_generator_reader: conversion table, directed pacing/underrun/drain/reset
// sequences, and randomized runs against a cycle-indexed reference model.
module tb_funct_generator_reader;

    localparam int NCYC = 16384;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en_i = 1'b0;
    logic        div_load_i = 1'b0;
    logic [15:0] div_i = '0;
    logic        empty_i = 1'b0;
    logic [31:0] data_i = '0;
    logic        rd_en_o;
    logic [11:0] dac_data_o;
    logic        dac_valid_o;
    logic        underrun_o;
    logic [15:0] underrun_cnt_o;
    logic        busy_o;

    funct_generator_reader dut (
        .clk(clk), .rst(rst), .en_i(en_i), .div_load_i(div_load_i), .div_i(div_i),
        .empty_i(empty_i), .data_i(data_i), .rd_en_o(rd_en_o), .dac_data_o(dac_data_o),
        .dac_valid_o(dac_valid_o), .underrun_o(underrun_o),
        .underrun_cnt_o(underrun_cnt_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int          m_state;   // 0 idle, 1 run, 2 drain
    int          m_period;
    int          m_runk;
    int          m_drk;
    logic [11:0] m_code;
    logic [15:0] m_ucnt;
    int          cyc;
    bit          tick_h [NCYC];
    bit          und_h  [NCYC];
    logic [31:0] data_h [NCYC];

    int          rd_seen;
    int          vld_seen;
    logic [11:0] obs_codes[$];

    typedef struct {
        logic [31:0] data;
        logic [11:0] code;
    } vec_t;
    vec_t tab[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (cyc %0d): got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Sample value scaled to DAC LSBs (floor), shifted to offset binary, clamped.
    function automatic logic [11:0] ref_conv(input logic [31:0] s);
        int v;
        v = $signed(s) >>> 17;
        v = v + 2048;
        if (v < 0) v = 0;
        if (v > 4095) v = 4095;
        return v[11:0];
    endfunction

    task automatic model_reset();
        m_state = 0; m_period = 99; m_runk = 0; m_drk = 0;
        m_code = 12'h800; m_ucnt = '0; cyc = 0;
    endtask

    // One clock cycle: drive, check all outputs against the model at negedge, advance model.
    task automatic step(input logic en, input logic empty, input logic load,
                        input logic [15:0] div, input logic [31:0] data);
        bit tick, m_vld, m_und;
        en_i = en; empty_i = empty; div_load_i = load; div_i = div; data_i = data;
        @(negedge clk);
        m_vld = 0; m_und = 0;
        if (cyc >= 2 && tick_h[cyc-2]) begin
            if (und_h[cyc-2]) begin
                m_und = 1;
                if (m_ucnt != 16'hFFFF) m_ucnt = m_ucnt + 16'd1;
            end else begin
                m_vld = 1;
                m_code = ref_conv(data_h[cyc-1]);
            end
        end
        tick = (m_state == 1) && en && ((m_runk % (m_period + 1)) == 0);
        tick_h[cyc] = tick;
        und_h[cyc]  = tick && empty;
        data_h[cyc] = data;
        chk("rd_en", 32'(rd_en_o), 32'(tick && !empty));
        chk("dac_valid", 32'(dac_valid_o), 32'(m_vld));
        chk("underrun", 32'(underrun_o), 32'(m_und));
        chk("dac_data", 32'(dac_data_o), 32'(m_code));
        chk("underrun_cnt", 32'(underrun_cnt_o), 32'(m_ucnt));
        chk("busy", 32'(busy_o), 32'(m_state != 0));
        if (rd_en_o) rd_seen++;
        if (dac_valid_o) begin vld_seen++; obs_codes.push_back(dac_data_o); end
        case (m_state)
            0: begin
                if (load) m_period = int'(div);
                if (en) begin m_state = 1; m_runk = 0; m_ucnt = '0; end
            end
            1: begin
                if (!en) begin m_state = 2; m_drk = 0; end
                else m_runk++;
            end
            default: begin
                m_drk++;
                if (m_drk == 2) m_state = 0;
            end
        endcase
        cyc++;
        @(posedge clk); #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 16'd0, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b0; en_i = 0; div_load_i = 0; empty_i = 0; data_i = 32'h0;
        @(negedge clk);
        chk("rst_dac_data", 32'(dac_data_o), 32'h800);
        chk("rst_valid", 32'(dac_valid_o), 32'h0);
        chk("rst_underrun", 32'(underrun_o), 32'h0);
        chk("rst_ucnt", 32'(underrun_cnt_o), 32'h0);
        chk("rst_busy", 32'(busy_o), 32'h0);
        chk("rst_rd_en", 32'(rd_en_o), 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [11:0] held;
        logic [31:0] r;
        logic [31:0] seq2 [5];
        logic [11:0] exp2 [5];

        tab[0] = '{32'h0000_0000, 12'h800};
        tab[1] = '{32'h0800_0000, 12'hC00};
        tab[2] = '{32'hF800_0000, 12'h400};
        tab[3] = '{32'hF000_0000, 12'h000};
        tab[4] = '{32'h1000_0000, 12'hFFF};
        tab[5] = '{32'hE000_0000, 12'h000};
        tab[6] = '{32'h0FFF_FFFF, 12'hFFF};
        tab[7] = '{32'h8000_0000, 12'h000};
        tab[8] = '{32'h7FFF_FFFF, 12'hFFF};
        tab[9] = '{32'h0002_0000, 12'h801};
        seq2 = '{32'h0000_0000, 32'h0800_0000, 32'hF800_0000, 32'h1000_0000, 32'hE000_0000};
        exp2 = '{12'h800, 12'hC00, 12'h400, 12'hFFF, 12'h000};

        #2;
        do_reset();

        // Default period 99: reads on first RUN cycle then every 100 cycles.
        idle_cycles(2);
        step(1'b1, 1'b0, 1'b0, 16'd0, 32'h0400_0000);
        rd_seen = 0; vld_seen = 0;
        for (int i = 0; i < 201; i++) step(1'b1, 1'b0, 1'b0, 16'd0, 32'h0400_0000);
        chk("div99_rd_count", 32'(rd_seen), 32'd3);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 16'd0, 32'h0);
        chk("div99_valid_count", 32'(vld_seen), 32'd3);
        idle_cycles(1);

        // Period 3 with five distinct samples, one code every 4 cycles.
        step(1'b0, 1'b0, 1'b1, 16'd3, 32'h0);
        step(1'b1, 1'b0, 1'b0, 16'd0, 32'h0);
        obs_codes.delete();
        for (int c = 0; c < 20; c++)
            step(1'b1, 1'b0, 1'b0, 16'd0, (c == 0) ? 32'h0 : seq2[(c-1)/4]);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 16'd0, 32'h0);
        chk("div3_ncodes", 32'(obs_codes.size()), 32'd5);
        for (int k = 0; k < 5; k++)
            if (k < obs_codes.size()) chk("div3_code", 32'(obs_codes[k]), 32'(exp2[k]));

        // Conversion table at full throughput (period 0).
        step(1'b0, 1'b0, 1'b1, 16'd0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 16'd0, 32'h0);
        obs_codes.delete();
        step(1'b1, 1'b0, 1'b0, 16'd0, 32'h0);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 16'd0, tab[i].data);
        vld_seen = 0;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 16'd0, 32'h0);
        chk("tput_drain_codes", 32'(vld_seen), 32'd2);
        for (int i = 0; i < 10; i++)
            if (i < obs_codes.size()) chk("conv_table", 32'(obs_codes[i]), 32'(tab[i].code));
        chk("tput_busy_after_drain", 32'(busy_o), 32'd0);

        // Underrun: period 9, FIFO empty for 3 ticks.
        held = dac_data_o;
        step(1'b0, 1'b0, 1'b1, 16'd9, 32'h0);
        step(1'b1, 1'b1, 1'b0, 16'd0, 32'h0);
        rd_seen = 0;
        for (int i = 0; i < 30; i++) step(1'b1, 1'b1, 1'b0, 16'd0, 32'h0800_0000);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 16'd0, 32'h0);
        chk("und_rd_count", 32'(rd_seen), 32'd0);
        chk("und_count", 32'(underrun_cnt_o), 32'd3);
        chk("und_hold_data", 32'(dac_data_o), 32'(held));
        step(1'b1, 1'b0, 1'b0, 16'd0, 32'h0);
        chk("und_cnt_cleared", 32'(underrun_cnt_o), 32'd0);
        // div_load during RUN must not change the period (model keeps 9).
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 16'd2, 32'h0);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0, 16'd0, 32'h0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 16'd0, 32'h0);

        // Reset one cycle after a read: slot discarded, outputs at reset values.
        step(1'b0, 1'b0, 1'b1, 16'd4, 32'h0);
        step(1'b1, 1'b0, 1'b0, 16'd0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 16'd0, 32'h0800_0000);
        rst = 1'b0;
        #2;
        chk("midrst_dac_data", 32'(dac_data_o), 32'h800);
        chk("midrst_valid", 32'(dac_valid_o), 32'h0);
        chk("midrst_busy", 32'(busy_o), 32'h0);
        @(negedge clk);
        chk("midrst_valid_t2", 32'(dac_valid_o), 32'h0);
        chk("midrst_rd_en", 32'(rd_en_o), 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        model_reset();
        idle_cycles(3);

        // Randomized episodes against the model.
        for (int ep = 0; ep < 25; ep++) begin
            int len;
            step(1'b0, 1'b0, 1'b1, 16'($urandom_range(6, 0)), 32'h0);
            step(1'b0, 1'b0, 1'b0, 16'd0, 32'h0);
            len = $urandom_range(80, 10);
            for (int i = 0; i < len; i++) begin
                r = $urandom;
                if ($urandom_range(1, 0) == 1) r = $signed(r) >>> 3;
                step(1'b1, ($urandom_range(3, 0) == 0), ($urandom_range(7, 0) == 0),
                     16'($urandom_range(6, 0)), r);
            end
            len = $urandom_range(5, 3);
            for (int i = 0; i < len; i++)
                step(1'b0, ($urandom_range(1, 0) == 1), 1'b0, 16'd0, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/funct_generator_reader.md
Name: funct_generator_reader

Overview:
- Consumer at the read end of the sample FIFO that the function generator fills.
- Paces FIFO reads at a programmable sample period and converts each signed fixed-point sample to an unsigned offset-binary DAC code, with saturation.
- Drives a DAC data bus with a one-cycle valid strobe.
- Flags and counts underruns, i.e. a sample slot that finds the FIFO empty.

Parameters:
- DATA_WIDTH, 32: FIFO sample width, signed fixed point.
- INT_BITS, 4: integer bits of the sample, including sign. FRAC = DATA_WIDTH-INT_BITS (local).
- DAC_WIDTH, 12: DAC code width. Must be <= FRAC+1.
- DIV_WIDTH, 16: sample-period register width.
- RESET_DIV, 99: reset value of the period register.

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: asynchronous, active-low reset (asserted when 0).
- en_i, input, 1: run enable.
- div_load_i, input, 1: load div_i into the period register.
- div_i, input, DIV_WIDTH: sample period minus 1, in clk cycles.
- empty_i, input, 1: FIFO empty flag.
- data_i, input, DATA_WIDTH: FIFO read data, valid the cycle after rd_en_o.
- rd_en_o, output, 1: FIFO read strobe.
- dac_data_o, output, DAC_WIDTH: DAC code, offset binary.
- dac_valid_o, output, 1: one-cycle strobe when dac_data_o updates.
- underrun_o, output, 1: one-cycle underrun pulse.
- underrun_cnt_o, output, 16: saturating underrun count.
- busy_o, output, 1: high in RUN or DRAIN.

Behaviour:
- Reset (rst=0, asynchronous):
  - State IDLE; cnt=0; period=RESET_DIV.
  - rd_en_o=0, dac_valid_o=0, underrun_o=0, underrun_cnt_o=0, busy_o=0.
  - dac_data_o = midscale = 2^(DAC_WIDTH-1) (0x800 for 12 bits).
  - Reset mid-operation aborts immediately; any in-flight read is discarded.
- FSM states:
  - IDLE: div_load_i=1 loads period<=div_i. en_i=1 -> RUN, with cnt<=period and underrun_cnt_o<=0.
  - RUN: div_load_i is ignored. en_i=0 -> DRAIN. Tick = (cnt==period) && en_i. On a tick cnt<=0, otherwise cnt<=cnt+1. The first RUN cycle is therefore a tick, and ticks then repeat every period+1 cycles.
  - DRAIN: held 2 cycles so in-flight slots complete, then -> IDLE. No new ticks. en_i is ignored; re-entry to RUN only from IDLE.
- Slot pipeline, for a tick at cycle T:
  - T: if empty_i=0, rd_en_o=1 for exactly that cycle. If empty_i=1, rd_en_o=0 and the slot is marked as an underrun.
  - T+1: data_i is sampled and converted.
  - T+2, normal slot: dac_data_o is updated and dac_valid_o=1 for one cycle.
  - T+2, underrun slot: dac_data_o holds its previous value, dac_valid_o=0, underrun_o=1, and underrun_cnt_o increments, saturating at 0xFFFF.
- period=0 gives a tick every cycle; slots then overlap in the pipeline with full throughput, one code per cycle.
- Conversion:
  - Let s = data_i.
  - If s[DATA_WIDTH-1:FRAC] is not all-equal (|s| >= 1.0): positive s -> code = all ones; negative s -> code = 0.
  - Otherwise take bits s[FRAC : FRAC-DAC_WIDTH+1] and invert the MSB. Truncate, no rounding.
  - Results for Q4.28, 12 bits: 0x00000000 -> 0x800; 0x08000000 (+0.5) -> 0xC00; 0xF8000000 (-0.5) -> 0x400; 0xF0000000 (-1.0) -> 0x000; 0x10000000 (+1.0) -> 0xFFF (saturated); 0xE0000000 (-2.0) -> 0x000; 0x0FFFFFFF -> 0xFFF.
- Simultaneous events:
  - en_i falling on a would-be tick cycle: no tick, go to DRAIN.
  - empty_i deasserting in the same cycle as a tick is honoured (combinational sample at T).
  - Outputs are never driven with X.

Test Plan:
- Reset with RESET_DIV=99 and FIFO non-empty -> dac_data_o=0x800, all strobes 0. After en_i=1: rd_en_o pulses on the first RUN cycle, then every 100 cycles. dac_valid_o lags each rd_en_o by exactly 2 cycles.
- Load div_i=3 in IDLE, enable, and feed 0x00000000, 0x08000000, 0xF8000000, 0x10000000, 0xE0000000 -> codes 0x800, 0xC00, 0x400, 0xFFF, 0x000, one every 4 cycles.
- Hold empty_i=1 for 3 ticks with period=9 -> rd_en_o stays 0, underrun_o pulses at T+2 of each slot, underrun_cnt_o=3, dac_data_o holds its last value. Re-enable from IDLE -> count clears to 0.
- period=0 with a continuous non-empty FIFO -> rd_en_o high every cycle and dac_valid_o high every cycle from the third RUN cycle. Drop en_i -> rd_en_o stops immediately, the 2 pending codes still appear, busy_o falls after DRAIN, and the state is IDLE.
- Pull rst low one cycle after an rd_en_o pulse -> no dac_valid_o, dac_data_o=0x800, state IDLE. Also pulse div_load_i during RUN -> the period is unchanged.
